// File: rtl/autoconfig_zii.sv
// autoconfig_zii: Zorro II AUTOCONFIG responder for two on-board functions.
// The first function is 8 MB Fast RAM. The second is the IDE controller with its boot ROM.
// It serves the nibble-wide config ROM at $E8xxxx.
// It latches the base address that expansion.library writes for each function.
// It then opens the chain to the next board.
module autoconfig_zii #(
    parameter logic [15:0] MANUF_ID   = 16'h082C,
    parameter logic [7:0]  RAM_PROD   = 8'h01,
    parameter logic [7:0]  IDE_PROD   = 8'h02,
    parameter logic [31:0] SERIAL     = 32'h0,
    parameter logic [15:0] IDE_ROMVEC = 16'h0000,
    parameter int          RAM_ENABLE = 1
) (
    input  logic       C14M,
    input  logic       RESET_n,
    input  logic [7:0] A_HIGH,
    input  logic [5:0] A_LOW,
    input  logic       RW_n,
    input  logic       AS_CPU_n,
    input  logic       UDS_n,
    input  logic [3:0] D_IN,
    input  logic       CFGIN_n,
    output logic [3:0] D_OUT,
    output logic       D_OE,
    output logic       CFGOUT_n,
    output logic [2:0] BASE_RAM,
    output logic       RAM_CONFIGURED_n,
    output logic [7:0] BASE_IDE,
    output logic       IDE_CONFIGURED_n
);

    typedef enum logic [1:0] {S_RAM, S_IDE, S_DONE} state_t;

    localparam state_t START_STATE = (RAM_ENABLE != 0) ? S_RAM : S_IDE;

    // Register offsets as word indices (byte offset >> 1)
    localparam logic [5:0] OFF_BASE_HI = 6'h24;  // $48
    localparam logic [5:0] OFF_BASE_LO = 6'h25;  // $4A
    localparam logic [5:0] OFF_SHUTUP  = 6'h26;  // $4C

    // Inverted copies of the ROM fields; the bus reads them active-low
    localparam logic [15:0] MANUF_INV  = ~MANUF_ID;
    localparam logic [31:0] SERIAL_INV = ~SERIAL;
    localparam logic [15:0] ROMVEC_INV = ~IDE_ROMVEC;
    localparam logic [7:0]  RAM_P_INV  = ~RAM_PROD;
    localparam logic [7:0]  IDE_P_INV  = ~IDE_PROD;

    state_t     state_reg;
    logic       wr_done_reg;
    logic [3:0] lo_nib_reg;
    logic [3:0] d_out_reg;
    logic       d_oe_reg;
    logic       cfgout_n_reg;
    logic [2:0] base_ram_reg;
    logic       ram_cfg_n_reg;
    logic [7:0] base_ide_reg;
    logic       ide_cfg_n_reg;

    logic       cfg_hit;
    logic       wr_commit;
    logic       is_ide;
    logic [3:0] rd_nib;

    assign cfg_hit   = (A_HIGH == 8'hE8) && !AS_CPU_n && !CFGIN_n && (state_reg != S_DONE);
    assign wr_commit = cfg_hit && !RW_n && !UDS_n && !wr_done_reg;
    assign is_ide    = (state_reg == S_IDE);

    // Config ROM lookup for the function currently being configured
    always_comb begin
        rd_nib = 4'hF;
        case (A_LOW)
            6'h00: rd_nib = is_ide ? 4'hD : 4'hE;   // Zorro II, ROM vector / link-to-memory
            6'h01: rd_nib = is_ide ? 4'h1 : 4'h0;   // 64 KB / 8 MB
            6'h02: rd_nib = is_ide ? IDE_P_INV[7:4] : RAM_P_INV[7:4];
            6'h03: rd_nib = is_ide ? IDE_P_INV[3:0] : RAM_P_INV[3:0];
            6'h08: rd_nib = MANUF_INV[15:12];
            6'h09: rd_nib = MANUF_INV[11:8];
            6'h0A: rd_nib = MANUF_INV[7:4];
            6'h0B: rd_nib = MANUF_INV[3:0];
            // Only $18-$1E exist in this map, so the upper serial half is served
            6'h0C: rd_nib = SERIAL_INV[31:28];
            6'h0D: rd_nib = SERIAL_INV[27:24];
            6'h0E: rd_nib = SERIAL_INV[23:20];
            6'h0F: rd_nib = SERIAL_INV[19:16];
            6'h14: rd_nib = is_ide ? ROMVEC_INV[15:12] : 4'hF;
            6'h15: rd_nib = is_ide ? ROMVEC_INV[11:8]  : 4'hF;
            6'h16: rd_nib = is_ide ? ROMVEC_INV[7:4]   : 4'hF;
            6'h17: rd_nib = is_ide ? ROMVEC_INV[3:0]   : 4'hF;
            6'h20: rd_nib = 4'h0;
            6'h21: rd_nib = 4'h0;
            default: rd_nib = 4'hF;
        endcase
    end

    // Bus-cycle tracking, registered read data and base-address commit FSM
    always_ff @(posedge C14M or negedge RESET_n) begin
        if (!RESET_n) begin
            state_reg     <= START_STATE;
            wr_done_reg   <= 1'b0;
            lo_nib_reg    <= 4'h0;
            d_out_reg     <= 4'hF;
            d_oe_reg      <= 1'b0;
            cfgout_n_reg  <= 1'b1;
            base_ram_reg  <= 3'b000;
            ram_cfg_n_reg <= 1'b1;
            base_ide_reg  <= 8'h00;
            ide_cfg_n_reg <= 1'b1;
        end else begin
            // Drive only while a qualified read is in progress.
            // Losing AS, CFGIN or the address drops it on the next edge.
            d_oe_reg <= cfg_hit && RW_n;
            if (cfg_hit && RW_n)
                d_out_reg <= rd_nib;

            // One commit per bus cycle, however long the CPU holds the strobes
            if (AS_CPU_n)
                wr_done_reg <= 1'b0;
            else if (wr_commit)
                wr_done_reg <= 1'b1;

            if (wr_commit) begin
                case (A_LOW)
                    OFF_BASE_HI: begin
                        if (state_reg == S_RAM) begin
                            base_ram_reg  <= D_IN[3:1];
                            ram_cfg_n_reg <= 1'b0;
                            state_reg     <= S_IDE;
                        end else begin
                            base_ide_reg  <= {D_IN, lo_nib_reg};
                            ide_cfg_n_reg <= 1'b0;
                            state_reg     <= S_DONE;
                            cfgout_n_reg  <= 1'b0;
                        end
                    end
                    OFF_BASE_LO: begin
                        if (state_reg == S_IDE)
                            lo_nib_reg <= D_IN;
                    end
                    OFF_SHUTUP: begin
                        if (state_reg == S_RAM) begin
                            state_reg <= S_IDE;
                        end else begin
                            state_reg    <= S_DONE;
                            cfgout_n_reg <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign D_OUT            = d_out_reg;
    assign D_OE             = d_oe_reg;
    assign CFGOUT_n         = cfgout_n_reg;
    assign BASE_RAM         = base_ram_reg;
    assign RAM_CONFIGURED_n = ram_cfg_n_reg;
    assign BASE_IDE         = base_ide_reg;
    assign IDE_CONFIGURED_n = ide_cfg_n_reg;

endmodule

// File: tb/tb_autoconfig_zii.sv
// tb_autoconfig_zii: drives CPU-style AUTOCONFIG bus cycles into autoconfig_zii.
// It checks the config ROM map, the base-address commits, the chain output and the reset behaviour.
module tb_autoconfig_zii;

    logic       C14M = 1'b0;
    logic       RESET_n;
    logic [7:0] A_HIGH;
    logic [5:0] A_LOW;
    logic       RW_n;
    logic       AS_CPU_n;
    logic       UDS_n;
    logic [3:0] D_IN;
    logic       CFGIN_n;
    logic [3:0] D_OUT;
    logic       D_OE;
    logic       CFGOUT_n;
    logic [2:0] BASE_RAM;
    logic       RAM_CONFIGURED_n;
    logic [7:0] BASE_IDE;
    logic       IDE_CONFIGURED_n;

    int errors = 0;
    int checks = 0;

    logic [3:0] sb_q[$];

    typedef struct {
        logic [6:0] off;   // byte offset
        logic [3:0] exp;   // expected nibble
    } rd_vec_t;

    rd_vec_t ram_tbl[16];
    rd_vec_t ide_tbl[8];

    autoconfig_zii dut (
        .C14M             (C14M),
        .RESET_n          (RESET_n),
        .A_HIGH           (A_HIGH),
        .A_LOW            (A_LOW),
        .RW_n             (RW_n),
        .AS_CPU_n         (AS_CPU_n),
        .UDS_n            (UDS_n),
        .D_IN             (D_IN),
        .CFGIN_n          (CFGIN_n),
        .D_OUT            (D_OUT),
        .D_OE             (D_OE),
        .CFGOUT_n         (CFGOUT_n),
        .BASE_RAM         (BASE_RAM),
        .RAM_CONFIGURED_n (RAM_CONFIGURED_n),
        .BASE_IDE         (BASE_IDE),
        .IDE_CONFIGURED_n (IDE_CONFIGURED_n)
    );

    always #35 C14M = ~C14M;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end else begin
            $display("check %s: %h ok", name, act);
        end
    endtask

    task automatic bus_idle();
        AS_CPU_n = 1'b1;
        UDS_n    = 1'b1;
        RW_n     = 1'b1;
        A_HIGH   = 8'h00;
    endtask

    // Full read cycle: push expectation, wait for the DUT to drive, pop and compare
    task automatic do_read(input logic [6:0] off, input logic [3:0] exp);
        bit got;
        logic [3:0] e;
        @(negedge C14M);
        A_HIGH = 8'hE8; A_LOW = off[6:1]; RW_n = 1'b1; AS_CPU_n = 1'b0; UDS_n = 1'b0;
        sb_q.push_back(exp);
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge C14M);
            if (D_OE === 1'b1) got = 1'b1;
        end
        e = sb_q.pop_front();
        if (!got)
            check($sformatf("rd_oe_%02h", off), {7'b0, D_OE}, 8'h01);
        else
            check($sformatf("rd_%02h", off), {4'h0, D_OUT}, {4'h0, e});
        bus_idle();
        @(negedge C14M);
        check($sformatf("rd_release_%02h", off), {7'b0, D_OE}, 8'h00);
    endtask

    // Read cycle that must never be answered
    task automatic do_read_silent(input string name, input logic [6:0] off);
        logic seen;
        @(negedge C14M);
        A_HIGH = 8'hE8; A_LOW = off[6:1]; RW_n = 1'b1; AS_CPU_n = 1'b0; UDS_n = 1'b0;
        seen = 1'b0;
        repeat (5) begin
            @(negedge C14M);
            if (D_OE !== 1'b0) seen = 1'b1;
        end
        check(name, {7'b0, seen}, 8'h00);
        bus_idle();
        @(negedge C14M);
    endtask

    // Write cycle held for 'hold' clocks with the given UDS_n level
    task automatic do_write(input logic [6:0] off, input logic [3:0] d, input int hold, input logic uds);
        @(negedge C14M);
        A_HIGH = 8'hE8; A_LOW = off[6:1]; RW_n = 1'b0; AS_CPU_n = 1'b0; UDS_n = uds; D_IN = d;
        repeat (hold) @(negedge C14M);
        bus_idle();
        @(negedge C14M);
        $display("write off=%02h data=%h hold=%0d uds_n=%b", off, d, hold, uds);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_doe"},      {7'b0, D_OE}, 8'h00);
        check({tag, "_dout"},     {4'h0, D_OUT}, 8'h0F);
        check({tag, "_cfgout"},   {7'b0, CFGOUT_n}, 8'h01);
        check({tag, "_base_ram"}, {5'b0, BASE_RAM}, 8'h00);
        check({tag, "_base_ide"}, BASE_IDE, 8'h00);
        check({tag, "_ram_cfg"},  {7'b0, RAM_CONFIGURED_n}, 8'h01);
        check({tag, "_ide_cfg"},  {7'b0, IDE_CONFIGURED_n}, 8'h01);
    endtask

    initial begin
        // RAM function map with default parameters.
        // Product 8'h01 inverted is 8'hFE. MANUF 16'h082C inverted is 16'hF7D3.
        ram_tbl[0]  = '{7'h00, 4'hE};
        ram_tbl[1]  = '{7'h02, 4'h0};
        ram_tbl[2]  = '{7'h04, 4'hF};
        ram_tbl[3]  = '{7'h06, 4'hE};
        ram_tbl[4]  = '{7'h08, 4'hF};
        ram_tbl[5]  = '{7'h0A, 4'hF};
        ram_tbl[6]  = '{7'h10, 4'hF};
        ram_tbl[7]  = '{7'h12, 4'h7};
        ram_tbl[8]  = '{7'h14, 4'hD};
        ram_tbl[9]  = '{7'h16, 4'h3};
        ram_tbl[10] = '{7'h18, 4'hF};
        ram_tbl[11] = '{7'h1E, 4'hF};
        ram_tbl[12] = '{7'h28, 4'hF};
        ram_tbl[13] = '{7'h40, 4'h0};
        ram_tbl[14] = '{7'h42, 4'h0};
        ram_tbl[15] = '{7'h0C, 4'hF};
        // IDE function map: product 8'h02 inverted is 8'hFD; ROM vector 0 inverted is $FFFF
        ide_tbl[0] = '{7'h00, 4'hD};
        ide_tbl[1] = '{7'h02, 4'h1};
        ide_tbl[2] = '{7'h04, 4'hF};
        ide_tbl[3] = '{7'h06, 4'hD};
        ide_tbl[4] = '{7'h12, 4'h7};
        ide_tbl[5] = '{7'h28, 4'hF};
        ide_tbl[6] = '{7'h2E, 4'hF};
        ide_tbl[7] = '{7'h40, 4'h0};

        bus_idle();
        A_LOW = 6'h00; D_IN = 4'h0; CFGIN_n = 1'b0;
        RESET_n = 1'b0;
        #200;
        check_reset_outputs("reset");
        @(negedge C14M);
        RESET_n = 1'b1;

        // RAM function ROM
        for (int i = 0; i < 16; i++)
            do_read(ram_tbl[i].off, ram_tbl[i].exp);
        check("ram_cfgout_before", {7'b0, CFGOUT_n}, 8'h01);

        // Base write without UDS_n is ignored
        do_write(7'h48, 4'h2, 3, 1'b1);
        check("uds_ignored_ram_cfg", {7'b0, RAM_CONFIGURED_n}, 8'h01);

        // Base write held 20 clocks: RAM commits once, IDE must not
        do_write(7'h48, 4'h2, 20, 1'b0);
        check("ram_base", {5'b0, BASE_RAM}, 8'h01);
        check("ram_cfg", {7'b0, RAM_CONFIGURED_n}, 8'h00);
        check("held_ide_cfg", {7'b0, IDE_CONFIGURED_n}, 8'h01);
        check("held_base_ide", BASE_IDE, 8'h00);
        check("held_cfgout", {7'b0, CFGOUT_n}, 8'h01);

        // IDE function ROM
        for (int i = 0; i < 8; i++)
            do_read(ide_tbl[i].off, ide_tbl[i].exp);

        // Write to an unrelated offset is ignored
        do_write(7'h40, 4'h5, 3, 1'b0);
        check("other_off_ide_cfg", {7'b0, IDE_CONFIGURED_n}, 8'h01);

        // Low nibble then high nibble commits IDE base
        do_write(7'h4A, 4'h9, 3, 1'b0);
        check("lo_nib_no_advance", {7'b0, IDE_CONFIGURED_n}, 8'h01);
        do_write(7'h48, 4'hE, 3, 1'b0);
        check("ide_base", BASE_IDE, 8'hE9);
        check("ide_cfg", {7'b0, IDE_CONFIGURED_n}, 8'h00);
        check("done_cfgout", {7'b0, CFGOUT_n}, 8'h00);
        check("done_ram_base_kept", {5'b0, BASE_RAM}, 8'h01);
        do_read_silent("done_silent", 7'h00);

        // Reset re-arms; then shut-up in S_RAM skips to IDE
        RESET_n = 1'b0;
        #1;
        check_reset_outputs("rearm");
        @(negedge C14M);
        RESET_n = 1'b1;
        do_write(7'h4C, 4'h0, 3, 1'b0);
        check("shutup_ram_cfg", {7'b0, RAM_CONFIGURED_n}, 8'h01);
        check("shutup_base_ram", {5'b0, BASE_RAM}, 8'h00);
        check("shutup_cfgout", {7'b0, CFGOUT_n}, 8'h01);
        do_read(7'h00, 4'hD);
        do_read(7'h02, 4'h1);

        // Reset mid-read in S_IDE drops D_OE immediately
        @(negedge C14M);
        A_HIGH = 8'hE8; A_LOW = 6'h00; RW_n = 1'b1; AS_CPU_n = 1'b0; UDS_n = 1'b0;
        @(negedge C14M);
        check("midread_oe_on", {7'b0, D_OE}, 8'h01);
        #10;
        RESET_n = 1'b0;
        #1;
        check_reset_outputs("midread");
        bus_idle();
        @(negedge C14M);
        RESET_n = 1'b1;
        do_read(7'h00, 4'hE);   // back in S_RAM

        // CFGIN_n high: never respond, never commit
        CFGIN_n = 1'b1;
        do_read_silent("cfgin_silent", 7'h00);
        do_write(7'h48, 4'h6, 3, 1'b0);
        check("cfgin_no_commit", {7'b0, RAM_CONFIGURED_n}, 8'h01);
        check("cfgin_base_ram", {5'b0, BASE_RAM}, 8'h00);
        CFGIN_n = 1'b0;

        // CFGIN_n rising mid-read drops D_OE on the next edge
        @(negedge C14M);
        A_HIGH = 8'hE8; A_LOW = 6'h01; RW_n = 1'b1; AS_CPU_n = 1'b0; UDS_n = 1'b0;
        @(negedge C14M);
        check("cfgin_mid_oe_on", {7'b0, D_OE}, 8'h01);
        CFGIN_n = 1'b1;
        @(negedge C14M);
        check("cfgin_mid_oe_off", {7'b0, D_OE}, 8'h00);
        bus_idle();
        CFGIN_n = 1'b0;
        @(negedge C14M);

        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_leftover: got %0d entries, expected 0", sb_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
